pipe_stage_buffer: RTL and testbench

Two-entry skid-buffered pipeline stage register with valid/ready handshake. It is the consuming side of the processor's enable-gated storage: it decides when the next stage's data is captured and held. Upstream stalls come from the downstream `out_ready`, not from a global enable. It sits between processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It provides full throughput, a registered `in_ready`, in-order delivery and a synchronous flush for branch squash.

---
 rtl/pipe_stage_buffer.sv | 93 +++++++++
 tb/tb_pipe_stage_buffer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid-buffered pipeline stage register with a valid/ready handshake,
// a registered in_ready and a synchronous flush for branch squash.
module pipe_stage_buffer #(
    parameter int   WIDTH = 64,
    parameter logic RESET = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush
);

    if (WIDTH < 1) begin : g_width_check
        $error("pipe_stage_buffer: WIDTH must be greater than 0");
    end

    // State bits are {skid_v, main_v}; 2'b10 is never a legal encoding.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_v;
    logic             skid_v;
    logic             accept;
    logic             take;

    assign main_v    = state[0];
    assign skid_v    = state[1];
    assign out_valid = main_v;
    assign out_data  = main_data;
    assign accept    = in_valid & in_ready;
    assign take      = main_v & out_ready;

    // in_ready is tracked as its own flop so it never depends on out_ready within a cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            // NOTE: only two data words exist, so resetting them is cheap and makes out_data known after reset.
            main_data <= {WIDTH{RESET}};
            skid_data <= {WIDTH{RESET}};
        end else if (flush) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= in_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_data <= in_data;
                    end else if (accept) begin
                        skid_data <= in_data;
                        state     <= FULL;
                        in_ready  <= 1'b0;
                    end else if (take) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        main_data <= skid_data;
                        state     <= ONE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    a_no_orphan_skid: assert property (@(posedge clk) disable iff (reset) !(skid_v && !main_v))
        else $error("pipe_stage_buffer: skid entry held without a main entry");

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: directed scenarios plus random traffic,
// scored against an occupancy/queue reference model.
module tb_pipe_stage_buffer;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         flush;

    // Second instance with RESET = 1 is only ever reset and left idle.
    logic         in_valid1  = 1'b0;
    logic [7:0]   in_data1   = 8'h5A;
    logic         in_ready1;
    logic         out_valid1;
    logic [7:0]   out_data1;
    logic         out_ready1 = 1'b0;
    logic         flush1     = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_buffer #(.WIDTH(W), .RESET(1'b0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .flush(flush)
    );

    pipe_stage_buffer #(.WIDTH(8), .RESET(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready1), .flush(flush1)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Present one cycle of inputs, then return #1 after the edge that samples them.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic fl = 1'b0, input logic rs = 1'b0);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of capacity two. Ready means fewer than two entries are
    // held; the head is what the DUT must show. Outputs are scored first, then the
    // handshakes of this cycle update the model exactly as the coming edge will.
    always @(negedge clk) begin
        bit rdy_m;
        bit take_m;
        rdy_m  = exp_q.size() < 2;
        take_m = (exp_q.size() > 0) && out_ready;
        check("in_ready", {63'd0, in_ready}, {63'd0, rdy_m});
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
        if (take_m) void'(exp_q.pop_front());
        if (reset || flush) exp_q.delete();
        else if (in_valid && rdy_m) exp_q.push_back(in_data);
    end

    initial begin
        // Reset held for two edges while upstream offers 32.
        cycle(1'b1, 64'd32, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 64'd32, 1'b0, 1'b0, 1'b1);
        check("reset_out_data", out_data, '0);
        check("reset_out_data_ones", {56'd0, out_data1}, {56'd0, 8'hFF});
        check("reset_out_valid_ones", {63'd0, out_valid1}, '0);
        cycle(1'b1, 64'd43, 1'b0);
        check("first_after_reset", out_data, 64'd43);
        cycle(1'b0, 64'd0, 1'b1);
        cycle(1'b0, 64'd0, 1'b1);

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b1);
        cycle(1'b0, 64'd0, 1'b1);
        cycle(1'b0, 64'd0, 1'b1);

        // Backpressure: 12 is refused while full and re-presented.
        cycle(1'b1, 64'd10, 1'b0);
        cycle(1'b1, 64'd11, 1'b0);
        cycle(1'b1, 64'd12, 1'b0);
        cycle(1'b1, 64'd12, 1'b0);
        cycle(1'b1, 64'd12, 1'b1);
        cycle(1'b1, 64'd12, 1'b1);
        cycle(1'b0, 64'd0, 1'b1);
        cycle(1'b0, 64'd0, 1'b1);

        // Accept and take together while one entry is held.
        cycle(1'b1, 64'hA, 1'b0);
        cycle(1'b1, 64'hB, 1'b1);
        cycle(1'b1, 64'hA, 1'b1);
        cycle(1'b1, 64'hB, 1'b1);
        cycle(1'b0, 64'd0, 1'b1);
        cycle(1'b0, 64'd0, 1'b1);

        // Flush while full; 5, 6 and 7 must never appear.
        cycle(1'b1, 64'd5, 1'b0);
        cycle(1'b1, 64'd6, 1'b0);
        cycle(1'b1, 64'd7, 1'b0, 1'b1);
        cycle(1'b1, 64'd8, 1'b0);
        check("after_flush", out_data, 64'd8);
        cycle(1'b0, 64'd0, 1'b1);
        cycle(1'b0, 64'd0, 1'b1);

        // Reset while full and draining.
        cycle(1'b1, 64'd20, 1'b0);
        cycle(1'b1, 64'd21, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        check("midreset_out_data_ones", {56'd0, out_data1}, {56'd0, 8'hFF});
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 250) == 0);
        end

        // Drain and confirm nothing is left outstanding.
        for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b1);
        check("drained", W'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
